// File: rtl/div15_seq_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master side issues operands and consumes results; the divider is the slave.
interface div15_seq_if #(parameter int WIDTH = 15);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/div15_seq.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock.
// Operands arrive and results leave over valid/ready; operations never overlap.
module div15_seq #(
    parameter int WIDTH = 15
) (
    input logic         clk,
    input logic         rst,
    div15_seq_if.slave  bus
);
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] qreg;
    logic [WIDTH-1:0] dreg;
    logic [WIDTH-1:0] pr;
    logic [CW-1:0]    count;
    logic             dbz;
    logic [WIDTH:0]   pr_shift;
    logic [WIDTH:0]   trial;

    // The partial remainder always stays below the divisor, so its stored top
    // bit would be constant zero; only the shifted trial value needs WIDTH+1 bits.
    assign pr_shift = {pr, qreg[WIDTH-1]};
    assign trial    = pr_shift + ~{1'b0, dreg} + {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            qreg  <= '0;
            dreg  <= '0;
            pr    <= '0;
            count <= '0;
            dbz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dreg  <= bus.divisor;
                        count <= CNT_INIT;
                        if (bus.divisor == '0) begin
                            qreg  <= '1;
                            pr    <= bus.dividend;
                            dbz   <= 1'b1;
                            state <= DONE;
                        end else begin
                            qreg  <= bus.dividend;
                            pr    <= '0;
                            dbz   <= 1'b0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // A clear top bit of the trial means no borrow: keep the difference.
                    if (!trial[WIDTH]) begin
                        pr   <= trial[WIDTH-1:0];
                        qreg <= {qreg[WIDTH-2:0], 1'b1};
                    end else begin
                        pr   <= pr_shift[WIDTH-1:0];
                        qreg <= {qreg[WIDTH-2:0], 1'b0};
                    end
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.busy        = (state == CALC);
    assign bus.quotient    = qreg;
    assign bus.remainder   = pr;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_div15_seq.sv
// Directed and randomised checks of div15_seq against hand-computed results.
// Latency is counted in clock edges including the accept edge.
module tb_div15_seq;
    localparam int WIDTH = 15;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    div15_seq_if #(.WIDTH(WIDTH)) bus ();

    div15_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Waits (bounded) for in_ready, then presents operands across one edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int edges);
        edges = 1;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic runDivide(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input int eq, input int er, input int edbz, input int elat);
        int n;
        applyStimulus(a, b);
        waitResult(n);
        checkOutput({tag, ".latency"}, n, elat);
        checkOutput({tag, ".q"}, bus.quotient, eq);
        checkOutput({tag, ".r"}, bus.remainder, er);
        checkOutput({tag, ".dbz"}, bus.div_by_zero, edbz);
        @(posedge clk);
        #1;
        checkOutput({tag, ".valid_drop"}, bus.out_valid, 0);
        checkOutput({tag, ".ready_back"}, bus.in_ready, 1);
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        #12;
        checkOutput("reset.in_ready", bus.in_ready, 1);
        checkOutput("reset.out_valid", bus.out_valid, 0);
        checkOutput("reset.busy", bus.busy, 0);
        checkOutput("reset.dbz", bus.div_by_zero, 0);
        checkOutput("reset.q", bus.quotient, 0);
        checkOutput("reset.r", bus.remainder, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic divide, with busy observed one edge into CALC.
        applyStimulus(15'd100, 15'd7);
        checkOutput("basic.busy", bus.busy, 1);
        checkOutput("basic.in_ready", bus.in_ready, 0);
        waitResult(n);
        checkOutput("basic.latency", n, 16);
        checkOutput("basic.q", bus.quotient, 14);
        checkOutput("basic.r", bus.remainder, 2);
        checkOutput("basic.dbz", bus.div_by_zero, 0);
        @(posedge clk);
        #1;
        checkOutput("basic.valid_drop", bus.out_valid, 0);

        runDivide("max_by_1", 15'd32767, 15'd1, 32767, 0, 0, 16);
        runDivide("max_by_max", 15'd32767, 15'd32767, 1, 0, 0, 16);
        runDivide("small_by_big", 15'd5, 15'd9, 0, 5, 0, 16);
        runDivide("zero_by_3", 15'd0, 15'd3, 0, 0, 0, 16);
        runDivide("dbz", 15'd1234, 15'd0, 32767, 1234, 1, 1);
        runDivide("after_dbz", 15'd10, 15'd3, 3, 1, 0, 16);

        // Back-pressure: result held for 10 cycles while new operands are offered.
        bus.out_ready = 1'b0;
        applyStimulus(15'd1000, 15'd7);
        waitResult(n);
        checkOutput("bp.latency", n, 16);
        bus.dividend = 15'd5;
        bus.divisor  = 15'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp.valid", bus.out_valid, 1);
            checkOutput("bp.q", bus.quotient, 142);
            checkOutput("bp.r", bus.remainder, 6);
            checkOutput("bp.in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("bp.valid_drop", bus.out_valid, 0);
        checkOutput("bp.in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        checkOutput("bp.no_accept", bus.busy, 0);

        // Asynchronous reset five edges into CALC.
        applyStimulus(15'd1000, 15'd3);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midrst.busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst.in_ready", bus.in_ready, 1);
        checkOutput("midrst.out_valid", bus.out_valid, 0);
        checkOutput("midrst.busy", bus.busy, 0);
        checkOutput("midrst.q", bus.quotient, 0);
        checkOutput("midrst.r", bus.remainder, 0);
        checkOutput("midrst.dbz", bus.div_by_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst.no_emit", bus.out_valid, 0);
        runDivide("post_rst", 15'd1000, 15'd3, 333, 1, 0, 16);

        // Random operands with random idle gaps and result back-pressure.
        for (int k = 0; k < 400; k++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            int eq;
            int er;
            int elat;
            a = WIDTH'($urandom_range(0, 32767));
            case ($urandom_range(0, 9))
                0:       b = '0;
                1, 2:    b = WIDTH'($urandom_range(1, 15));
                default: b = WIDTH'($urandom_range(1, 32767));
            endcase
            if (b == '0) begin
                eq   = 32767;
                er   = int'(a);
                elat = 1;
            end else begin
                eq   = int'(a) / int'(b);
                er   = int'(a) % int'(b);
                elat = 16;
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(a, b);
            n = 1;
            while (!bus.out_valid && n < 40) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                @(posedge clk);
                #1;
                n++;
            end
            bus.out_ready = 1'b0;
            checkOutput("rand.latency", n, elat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            checkOutput("rand.valid", bus.out_valid, 1);
            checkOutput("rand.q", bus.quotient, eq);
            checkOutput("rand.r", bus.remainder, er);
            checkOutput("rand.dbz", bus.div_by_zero, (b == '0) ? 1 : 0);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("rand.one_output", bus.out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
